// File: rtl/btn_debounce.sv
// Per-channel push-button conditioner: two-flop synchroniser, debounce counter,
// then a registered clean level, a one-cycle press pulse and a press-toggled bit.
//
// state   | meaning
// STABLE  | synchronised input agrees with btn_lvl, counter idle at 0
// PENDING | input differs from btn_lvl, counting consecutive samples toward accept
module btn_debounce #(
  parameter int              NBTN            = 5,
  parameter int              DEBOUNCE_CYCLES = 1000000,
  parameter logic [NBTN-1:0] TGL_INIT        = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_lvl,
  output logic [NBTN-1:0] btn_one,
  output logic [NBTN-1:0] btn_tgl
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [0:0]    st;
    logic          lvl;
    logic          one;
    logic          tgl;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        cnt <= '0;
        st  <= ST_STABLE;
        lvl <= 1'b0;
        one <= 1'b0;
        tgl <= TGL_INIT[i];
      end else begin
        s1  <= btn_in[i];
        s2  <= s1;
        one <= 1'b0;
        case (st)
          ST_STABLE: begin
            if (s2 != lvl) begin
              // With DEBOUNCE_CYCLES == 1 the first differing sample is accepted directly.
              if (cnt == CNT_LAST) begin
                lvl <= s2;
                one <= s2;
                tgl <= tgl ^ s2;
                cnt <= '0;
              end else begin
                cnt <= cnt + 1'b1;
                st  <= ST_PENDING;
              end
            end
          end
          default: begin
            if (s2 == lvl) begin
              cnt <= '0;
              st  <= ST_STABLE;
            end else if (cnt == CNT_LAST) begin
              lvl <= s2;
              one <= s2;
              tgl <= tgl ^ s2;
              cnt <= '0;
              st  <= ST_STABLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end

    assign btn_lvl[i] = lvl;
    assign btn_one[i] = one;
    assign btn_tgl[i] = tgl;
  end

endmodule
